// File: rtl/dot_product_loader_if.sv
// Element-pair stream into the dot-product loader: one (a, b) pair per
// valid/ready handshake, with s_last marking the final pair of a vector.
interface dot_product_loader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data_a;
  logic [DATA_WIDTH-1:0] s_data_b;
  logic                  s_last;

  modport master (
    output s_valid,
    output s_data_a,
    output s_data_b,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data_a,
    input  s_data_b,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/dot_product_loader.sv
// Streams element pairs into the dot-product system's A/B memories, then
// starts processing and holds off the next vector until the system finishes.
module dot_product_loader #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  dot_product_loader_if.slave   s,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  start_reading,
  input  logic                  reading_done,
  input  logic                  writer_done,
  output logic                  busy,
  output logic                  vec_done,
  output logic [7:0]            vec_count,
  output logic                  err_last
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    START      = 3'd2,
    WAIT_READ  = 3'd3,
    WAIT_WRITE = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VECTOR_WIDTH - 1);

  state_t                state_r;
  state_t                next_state_s;
  logic [ADDR_WIDTH-1:0] idx_r;
  logic                  wd_seen_r;
  logic                  write_en_r;
  logic [ADDR_WIDTH-1:0] write_addr_r;
  logic [DATA_WIDTH-1:0] data_a_r;
  logic [DATA_WIDTH-1:0] data_b_r;
  logic                  start_reading_r;
  logic                  busy_r;
  logic                  vec_done_r;
  logic [7:0]            vec_count_r;
  logic                  err_last_r;
  logic                  accept_s;
  logic                  last_idx_s;
  logic                  complete_s;

  // Ready comes from the registered state alone so it never loops back through s_valid.
  assign s.s_ready  = (state_r == IDLE) || (state_r == LOAD);
  assign accept_s   = s.s_valid && s.s_ready;
  assign last_idx_s = (idx_r == LAST_IDX);

  assign write_en      = write_en_r;
  assign write_addr    = write_addr_r;
  assign data_a        = data_a_r;
  assign data_b        = data_b_r;
  assign start_reading = start_reading_r;
  assign busy          = busy_r;
  assign vec_done      = vec_done_r;
  assign vec_count     = vec_count_r;
  assign err_last      = err_last_r;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; complete_s marks the cycle a vector retires.
  always_comb begin
    next_state_s = state_r;
    complete_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = last_idx_s ? START : LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && last_idx_s) begin
          next_state_s = START;
        end else begin
          next_state_s = LOAD;
        end
      end
      START: begin
        next_state_s = WAIT_READ;
      end
      WAIT_READ: begin
        if (reading_done) begin
          next_state_s = WAIT_WRITE;
        end else begin
          next_state_s = WAIT_READ;
        end
      end
      WAIT_WRITE: begin
        if (writer_done || wd_seen_r) begin
          complete_s   = 1'b1;
          next_state_s = IDLE;
        end else begin
          complete_s   = 1'b0;
          next_state_s = WAIT_WRITE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Write port, element index, handshake latch and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r           <= '0;
      wd_seen_r       <= 1'b0;
      write_en_r      <= 1'b0;
      write_addr_r    <= '0;
      data_a_r        <= '0;
      data_b_r        <= '0;
      start_reading_r <= 1'b0;
      busy_r          <= 1'b0;
      vec_done_r      <= 1'b0;
      vec_count_r     <= 8'd0;
      err_last_r      <= 1'b0;
    end else begin
      write_en_r <= accept_s;
      if (accept_s) begin
        write_addr_r <= idx_r;
        data_a_r     <= s.s_data_a;
        data_b_r     <= s.s_data_b;
        idx_r        <= last_idx_s ? '0 : idx_r + ADDR_WIDTH'(1);
        if (s.s_last != last_idx_s) begin
          err_last_r <= 1'b1;
        end
      end
      // Registering off START places the pulse right after the final write strobe.
      start_reading_r <= (state_r == START);
      vec_done_r      <= complete_s;
      if (complete_s) begin
        vec_count_r <= vec_count_r + 8'd1;
      end
      if ((state_r == IDLE) && accept_s) begin
        busy_r <= 1'b1;
      end else if (complete_s) begin
        busy_r <= 1'b0;
      end
      if (complete_s) begin
        wd_seen_r <= 1'b0;
      end else if ((state_r == WAIT_READ) && writer_done) begin
        wd_seen_r <= 1'b1;
      end
    end
  end

endmodule
